// File: rtl/memory_copier.sv
// memory_copier: byte-at-a-time block copy between two regions of an 8-bit
// address space. Each byte takes a READ, WAIT and WRITE cycle. Requests that
// would write into ROM or past the output ports are rejected without any
// memory write.
module memory_copier (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic [7:0] src_addr,
    input  logic [7:0] dst_addr,
    input  logic [7:0] length,
    output logic       busy,
    output logic       done,
    output logic       error,
    output logic [7:0] mem_address,
    output logic [7:0] mem_data_in,
    output logic       mem_write,
    input  logic [7:0] mem_data_out
);

    typedef enum logic [2:0] {
        IDLE,
        READ,
        WAIT,
        WRITE,
        DONE
    } state_t;

    state_t     state;
    state_t     state_next;

    logic [7:0] sp;
    logic [7:0] dp;
    logic [7:0] remaining;
    logic [7:0] byte_q;
    logic       error_q;

    logic [8:0] dst_end;
    logic [8:0] src_end;
    logic       request_illegal;

    // Last byte touched on each side, computed 9 bits wide so a range that
    // runs off the top of the address space is caught instead of wrapping.
    // A zero-length request is never illegal, so the -1 underflow is harmless.
    assign dst_end = {1'b0, dst_addr} + {1'b0, length} - 9'd1;
    assign src_end = {1'b0, src_addr} + {1'b0, length} - 9'd1;

    assign request_illegal = (length != 8'd0) &&
                             ((dst_addr < 8'h80) ||
                              (dst_end > 9'h0EF) ||
                              (src_end > 9'h0FF));

    // State register; reset returns to IDLE and cancels any transfer in flight.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic: starts are only looked at in IDLE, and a rejected or
    // empty request goes straight to DONE.
    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (start) begin
                    if (!request_illegal && (length != 8'd0)) begin
                        state_next = READ;
                    end else begin
                        state_next = DONE;
                    end
                end
            end
            READ:  state_next = WAIT;
            WAIT:  state_next = WRITE;
            WRITE: state_next = (remaining > 8'd1) ? READ : DONE;
            DONE:  state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Datapath: capture the request, latch read data, and step the pointers
    // once per written byte. The error flag is stored so it remains visible
    // after DONE until the next accepted start.
    always_ff @(posedge clk) begin
        if (reset) begin
            sp        <= 8'h00;
            dp        <= 8'h00;
            remaining <= 8'h00;
            byte_q    <= 8'h00;
            error_q   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        sp        <= src_addr;
                        dp        <= dst_addr;
                        remaining <= length;
                        error_q   <= request_illegal;
                    end
                end
                WAIT: begin
                    byte_q <= mem_data_out;
                end
                WRITE: begin
                    sp        <= sp + 8'd1;
                    dp        <= dp + 8'd1;
                    remaining <= remaining - 8'd1;
                end
                default: begin
                end
            endcase
        end
    end

    // Outputs decoded from state alone: the memory bus is parked at zero
    // outside the transfer, and write enable exists only in WRITE.
    always_comb begin
        busy        = 1'b0;
        done        = 1'b0;
        mem_address = 8'h00;
        mem_data_in = 8'h00;
        mem_write   = 1'b0;
        case (state)
            READ: begin
                busy        = 1'b1;
                mem_address = sp;
            end
            WAIT: begin
                busy        = 1'b1;
                mem_address = sp;
            end
            WRITE: begin
                busy        = 1'b1;
                mem_address = dp;
                mem_data_in = byte_q;
                mem_write   = 1'b1;
            end
            DONE: begin
                done = 1'b1;
            end
            default: begin
            end
        endcase
    end

    assign error = error_q;

endmodule

// File: tb/tb_memory_copier.sv
// tb_memory_copier: drives copy requests into memory_copier against a
// 256-byte synchronous-read memory model. Expected writes come from a
// reference copy made at request time and are checked in order as the DUT
// issues them.
module tb_memory_copier;

    logic       clk;
    logic       reset;
    logic       start;
    logic [7:0] src_addr;
    logic [7:0] dst_addr;
    logic [7:0] length;
    logic       busy;
    logic       done;
    logic       error;
    logic [7:0] mem_address;
    logic [7:0] mem_data_in;
    logic       mem_write;
    logic [7:0] mem_data_out;

    logic [7:0]  mem [256];
    logic        poke_en;
    logic [7:0]  poke_addr;
    logic [7:0]  poke_data;

    logic [15:0] exp_q [$];
    int          compared;
    int          mismatched;
    int          write_count;
    int          done_count;

    memory_copier dut (
        .clk          (clk),
        .reset        (reset),
        .start        (start),
        .src_addr     (src_addr),
        .dst_addr     (dst_addr),
        .length       (length),
        .busy         (busy),
        .done         (done),
        .error        (error),
        .mem_address  (mem_address),
        .mem_data_in  (mem_data_in),
        .mem_write    (mem_write),
        .mem_data_out (mem_data_out)
    );

    // 10 ns clock
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Memory model: read data appears one cycle after the address, writes
    // commit on the edge; the bench preloads bytes through the same port.
    always @(posedge clk) begin
        mem_data_out <= mem[mem_address];
        if (mem_write === 1'b1) begin
            mem[mem_address] <= mem_data_in;
        end else if (poke_en) begin
            mem[poke_addr] <= poke_data;
        end
    end

    // Scoreboard: every DUT write must match the next expected {addr,data}.
    always @(negedge clk) begin
        logic [15:0] e;
        if (mem_write === 1'b1) begin
            write_count++;
            compared++;
            if (exp_q.size() == 0) begin
                mismatched++;
                $display("[TB] FAIL unexpected_write: got addr=%h data=%h, expected no write",
                         mem_address, mem_data_in);
            end else begin
                e = exp_q.pop_front();
                if ({mem_address, mem_data_in} !== e) begin
                    mismatched++;
                    $display("[TB] FAIL write_data: got addr=%h data=%h, expected addr=%h data=%h",
                             mem_address, mem_data_in, e[15:8], e[7:0]);
                end
            end
        end
        if (done === 1'b1) done_count++;
    end

    task automatic poke(input logic [7:0] a, input logic [7:0] d);
        @(negedge clk);
        poke_addr = a;
        poke_data = d;
        poke_en   = 1'b1;
        @(posedge clk);
        #1 poke_en = 1'b0;
    endtask

    // Issue one request, queue the expected writes from a reference copy,
    // and measure done latency, error, busy consistency and write/done counts.
    task automatic run_copy(input logic [7:0] s, input logic [7:0] d, input logic [7:0] l,
                            input bit pulse_busy,
                            output int latency, output logic err_seen,
                            output bit busy_bad, output int writes, output int dones);
        logic [7:0] model [256];
        logic [7:0] sa;
        logic [7:0] da;
        bit   illegal;
        int   exp_cycles;
        int   w0;
        int   d0;
        bit   got;
        illegal = (l != 0) && ((d < 8'h80) || (int'(d) + int'(l) - 1 > 239) ||
                               (int'(s) + int'(l) - 1 > 255));
        exp_cycles = (!illegal && l != 0) ? 3 * int'(l) + 1 : 1;
        if (!illegal) begin
            model = mem;
            for (int i = 0; i < int'(l); i++) begin
                sa = s + 8'(i);
                da = d + 8'(i);
                model[da] = model[sa];
                exp_q.push_back({da, model[da]});
            end
        end
        w0 = write_count;
        d0 = done_count;
        @(negedge clk);
        start    = 1'b1;
        src_addr = s;
        dst_addr = d;
        length   = l;
        @(posedge clk);
        #1 start = 1'b0;
        latency  = 0;
        got      = 1'b0;
        busy_bad = 1'b0;
        err_seen = 1'bx;
        while (latency < 2000 && !got) begin
            @(negedge clk);
            latency++;
            start = pulse_busy && (latency == 2 || latency == 5);
            if (busy !== (latency < exp_cycles && exp_cycles > 1)) busy_bad = 1'b1;
            if (done === 1'b1) begin
                got      = 1'b1;
                err_seen = error;
            end
        end
        start = 1'b0;
        repeat (3) @(negedge clk);
        writes = write_count - w0;
        dones  = done_count - d0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (2) @(negedge clk);
        compared++;
        if ({busy, done, error, mem_write, mem_address, mem_data_in} !== 20'h0) begin
            mismatched++;
            $display("[TB] FAIL reset_outputs: got busy=%b done=%b error=%b wr=%b addr=%h data=%h, expected all zero",
                     busy, done, error, mem_write, mem_address, mem_data_in);
        end
        reset = 1'b0;
    endtask

    task automatic test_basic_copy();
        int lat; logic err; bit bb; int w; int dn;
        poke(8'h00, 8'h11);
        poke(8'h01, 8'h22);
        poke(8'h02, 8'h33);
        run_copy(8'h00, 8'h80, 8'd3, 1'b0, lat, err, bb, w, dn);
        compared++;
        if (lat !== 10) begin mismatched++; $display("[TB] FAIL basic_latency: got %0d, expected 10", lat); end
        compared++;
        if (err !== 1'b0) begin mismatched++; $display("[TB] FAIL basic_error: got %b, expected 0", err); end
        compared++;
        if (bb) begin mismatched++; $display("[TB] FAIL basic_busy: got inconsistent busy, expected busy only in READ/WAIT/WRITE"); end
        compared++;
        if ({mem[8'h80], mem[8'h81], mem[8'h82]} !== 24'h112233) begin
            mismatched++;
            $display("[TB] FAIL basic_mem: got %h%h%h, expected 112233", mem[8'h80], mem[8'h81], mem[8'h82]);
        end
    endtask

    task automatic test_zero_length();
        int lat; logic err; bit bb; int w; int dn;
        run_copy(8'h10, 8'h90, 8'd0, 1'b0, lat, err, bb, w, dn);
        compared++;
        if (lat !== 1) begin mismatched++; $display("[TB] FAIL zero_latency: got %0d, expected 1", lat); end
        compared++;
        if (err !== 1'b0) begin mismatched++; $display("[TB] FAIL zero_error: got %b, expected 0", err); end
        compared++;
        if (w !== 0) begin mismatched++; $display("[TB] FAIL zero_writes: got %0d, expected 0", w); end
    endtask

    task automatic test_illegal();
        int lat; logic err; bit bb; int w; int dn;
        run_copy(8'h00, 8'h7F, 8'd1, 1'b0, lat, err, bb, w, dn);
        compared++;
        if (lat !== 1) begin mismatched++; $display("[TB] FAIL rom_latency: got %0d, expected 1", lat); end
        compared++;
        if (err !== 1'b1) begin mismatched++; $display("[TB] FAIL rom_error: got %b, expected 1", err); end
        compared++;
        if (w !== 0) begin mismatched++; $display("[TB] FAIL rom_writes: got %0d, expected 0", w); end
        compared++;
        if (error !== 1'b1) begin mismatched++; $display("[TB] FAIL error_held: got %b, expected 1", error); end
        run_copy(8'h00, 8'hEE, 8'd3, 1'b0, lat, err, bb, w, dn);
        compared++;
        if (err !== 1'b1 || w !== 0) begin
            mismatched++;
            $display("[TB] FAIL dst_end_error: got error=%b writes=%0d, expected error=1 writes=0", err, w);
        end
        run_copy(8'hFE, 8'h90, 8'd3, 1'b0, lat, err, bb, w, dn);
        compared++;
        if (err !== 1'b1 || w !== 0) begin
            mismatched++;
            $display("[TB] FAIL src_end_error: got error=%b writes=%0d, expected error=1 writes=0", err, w);
        end
    endtask

    task automatic test_boundary();
        int lat; logic err; bit bb; int w; int dn;
        poke(8'hFD, 8'hC1);
        poke(8'hFE, 8'hC2);
        poke(8'hFF, 8'hC3);
        run_copy(8'hFD, 8'hED, 8'd3, 1'b0, lat, err, bb, w, dn);
        compared++;
        if (err !== 1'b0 || lat !== 10 || w !== 3) begin
            mismatched++;
            $display("[TB] FAIL edge_copy: got error=%b latency=%0d writes=%0d, expected 0/10/3", err, lat, w);
        end
    endtask

    task automatic test_port_copy();
        int lat; logic err; bit bb; int w; int dn;
        poke(8'hF0, 8'hA5);
        run_copy(8'hF0, 8'hE0, 8'd1, 1'b0, lat, err, bb, w, dn);
        compared++;
        if (lat !== 4) begin mismatched++; $display("[TB] FAIL port_latency: got %0d, expected 4", lat); end
        compared++;
        if (mem[8'hE0] !== 8'hA5) begin mismatched++; $display("[TB] FAIL port_out: got %h, expected a5", mem[8'hE0]); end
    endtask

    task automatic test_reset_abort();
        int d0;
        poke(8'h00, 8'h11);
        poke(8'h01, 8'h22);
        for (int i = 0; i < 5; i++) poke(8'h80 + 8'(i), 8'h5A);
        exp_q.push_back({8'h80, 8'h11});
        exp_q.push_back({8'h81, 8'h22});
        d0 = done_count;
        @(negedge clk);
        start    = 1'b1;
        src_addr = 8'h00;
        dst_addr = 8'h80;
        length   = 8'd5;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (6) @(negedge clk);
        compared++;
        if (mem_write !== 1'b1 || mem_address !== 8'h81) begin
            mismatched++;
            $display("[TB] FAIL abort_second_write: got wr=%b addr=%h, expected wr=1 addr=81", mem_write, mem_address);
        end
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        compared++;
        if ({busy, done, mem_write, mem_address} !== 11'h0) begin
            mismatched++;
            $display("[TB] FAIL abort_outputs: got busy=%b done=%b wr=%b addr=%h, expected all zero",
                     busy, done, mem_write, mem_address);
        end
        repeat (4) @(negedge clk);
        compared++;
        if ({mem[8'h80], mem[8'h81], mem[8'h82]} !== 24'h11225A) begin
            mismatched++;
            $display("[TB] FAIL abort_mem: got %h%h%h, expected 11225a", mem[8'h80], mem[8'h81], mem[8'h82]);
        end
        compared++;
        if (done_count != d0 || exp_q.size() != 0) begin
            mismatched++;
            $display("[TB] FAIL abort_done: got dones=%0d pending=%0d, expected 0/0", done_count - d0, exp_q.size());
        end
    endtask

    task automatic test_back_to_back();
        int lat; logic err; bit bb; int w; int dn;
        poke(8'h02, 8'h33);
        run_copy(8'h00, 8'h80, 8'd3, 1'b0, lat, err, bb, w, dn);
        compared++;
        if (lat !== 10 || w !== 3 || err !== 1'b0) begin
            mismatched++;
            $display("[TB] FAIL restart_copy: got latency=%0d writes=%0d error=%b, expected 10/3/0", lat, w, err);
        end
        run_copy(8'h80, 8'h81, 8'd3, 1'b0, lat, err, bb, w, dn);
        compared++;
        if ({mem[8'h81], mem[8'h82], mem[8'h83]} !== 24'h111111) begin
            mismatched++;
            $display("[TB] FAIL overlap_mem: got %h%h%h, expected 111111", mem[8'h81], mem[8'h82], mem[8'h83]);
        end
    endtask

    task automatic test_start_while_busy();
        int lat; logic err; bit bb; int w; int dn;
        run_copy(8'h00, 8'hA0, 8'd4, 1'b1, lat, err, bb, w, dn);
        compared++;
        if (dn !== 1 || w !== 4 || lat !== 13) begin
            mismatched++;
            $display("[TB] FAIL busy_start: got dones=%0d writes=%0d latency=%0d, expected 1/4/13", dn, w, lat);
        end
        compared++;
        if (bb) begin mismatched++; $display("[TB] FAIL busy_level: got inconsistent busy, expected busy for 12 cycles"); end
    endtask

    initial begin
        compared    = 0;
        mismatched  = 0;
        write_count = 0;
        done_count  = 0;
        reset       = 1'b1;
        start       = 1'b0;
        src_addr    = 8'h00;
        dst_addr    = 8'h00;
        length      = 8'h00;
        poke_en     = 1'b0;
        poke_addr   = 8'h00;
        poke_data   = 8'h00;
        for (int i = 0; i < 256; i++) mem[i] = 8'h00;
        test_reset();
        test_basic_copy();
        test_zero_length();
        test_illegal();
        test_boundary();
        test_port_copy();
        test_reset_abort();
        test_back_to_back();
        test_start_while_busy();
        compared++;
        if (exp_q.size() != 0) begin
            mismatched++;
            $display("[TB] FAIL pending_writes: got %0d outstanding, expected 0", exp_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
